// File: rtl/picoctrl_pkg.sv
// rtl/picoctrl_pkg.sv - PicoCtrl instruction encoding, FSM state type and assembly helper
package picoctrl_pkg;

    localparam int INSTR_W = 16;

    // Instruction field bit positions
    localparam int COND_HI = 15;
    localparam int COND_LO = 13;
    localparam int ACT_HI  = 12;
    localparam int ACT_LO  = 10;
    localparam int SEL_HI  = 9;
    localparam int SEL_LO  = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    // Condition codes; 101..111 all evaluate as never
    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_C0_LO  = 3'b001;
    localparam logic [2:0] COND_C0_HI  = 3'b010;
    localparam logic [2:0] COND_C1_LO  = 3'b011;
    localparam logic [2:0] COND_C1_HI  = 3'b100;
    localparam logic [2:0] COND_NEVER  = 3'b101;

    // Action codes; 100..111 behave as nop
    localparam logic [2:0] ACT_NOP   = 3'b000;
    localparam logic [2:0] ACT_WRITE = 3'b001;
    localparam logic [2:0] ACT_JUMP  = 3'b010;
    localparam logic [2:0] ACT_HALT  = 3'b011;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Builds one instruction word; shared with the ROM image generator
    function automatic logic [INSTR_W-1:0] asm_instr(
        input logic [2:0] cond,
        input logic [2:0] act,
        input logic [1:0] sel,
        input logic [7:0] imm
    );
        return {cond, act, sel, imm};
    endfunction

endpackage

// File: rtl/picoctrl_sync.sv
// rtl/picoctrl_sync.sv - parameterized multi-flop 1-bit synchronizer for asynchronous inputs
module picoctrl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // STAGES must be at least 2 for metastability settling
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at bit 0; the oldest sample sits in the top bit
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer chain register; free-running, independent of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/picoctrl_core.sv
// rtl/picoctrl_core.sv - PicoCtrl sequencer/execute stage: pc, condition evaluation, output registers
module picoctrl_core
    import picoctrl_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              resume,
    input  logic              c0,
    input  logic              c1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [DATA_W-1:0] reg0_out,
    output logic [DATA_W-1:0] reg1_out,
    output logic [DATA_W-1:0] reg2_out,
    output logic [DATA_W-1:0] reg3_out,
    output logic              halted
);

    logic              c0_s;
    logic              c1_s;
    logic [2:0]        cond;
    logic [2:0]        act;
    logic [1:0]        sel;
    logic [7:0]        imm;
    logic              cond_true;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];

    picoctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_c0 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (c0),
        .q       (c0_s)
    );

    picoctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_c1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (c1),
        .q       (c1_s)
    );

    assign cond = rom_data[COND_HI:COND_LO];
    assign act  = rom_data[ACT_HI:ACT_LO];
    assign sel  = rom_data[SEL_HI:SEL_LO];
    assign imm  = rom_data[IMM_HI:IMM_LO];

    // Evaluate the condition field against the synchronized inputs only
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_ALWAYS: cond_true = 1'b1;
            COND_C0_LO:  cond_true = !c0_s;
            COND_C0_HI:  cond_true = c0_s;
            COND_C1_LO:  cond_true = !c1_s;
            COND_C1_HI:  cond_true = c1_s;
            default:     cond_true = 1'b0;
        endcase
    end

    // Next-state: execute one instruction per enabled cycle in RUN, wait for resume in HALT
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        regs_d  = regs_q;
        if (en) begin
            case (state_q)
                RUN: begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (cond_true) begin
                        case (act)
                            ACT_WRITE: regs_d[sel] = DATA_W'(imm);
                            ACT_JUMP:  pc_d = imm[ADDR_W-1:0];
                            ACT_HALT: begin
                                state_d = HALT;
                                pc_d    = pc_q;
                            end
                            default: ;
                        endcase
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_d = RUN;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, program counter and output register flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            state_q <= RUN;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    assign rom_addr = pc_q;
    assign reg0_out = regs_q[0];
    assign reg1_out = regs_q[1];
    assign reg2_out = regs_q[2];
    assign reg3_out = regs_q[3];
    assign halted   = (state_q == HALT);

endmodule

// File: doc/picoctrl_core.md
Name: picoctrl_core

Overview:
- Sequencer/execute stage of the PicoCtrl controller; sits directly downstream of the 32-entry instruction ROM.
- Drives the ROM address (program counter) and consumes the 16-bit instruction returned combinationally in the same cycle.
- Evaluates the condition against synchronized inputs c0/c1 and executes write, jump or halt.
- Drives four 8-bit output registers; reg0 feeds the LED bank.

Parameters:
- ADDR_W, 5, program counter / ROM address width (32 words).
- DATA_W, 8, immediate and output register width.
- SYNC_STAGES, 2, flip-flop stages on c0 and c1 (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  instruction-execute enable; when low, all state holds.
- resume  input  1  single-cycle pulse; leaves HALT.
- c0  input  1  asynchronous condition input 0.
- c1  input  1  asynchronous condition input 1.
- rom_addr  output  ADDR_W  = pc; combinational address to the ROM.
- rom_data  input  16  instruction for rom_addr, same cycle.
- reg0_out, reg1_out, reg2_out, reg3_out  output  DATA_W each  output registers.
- halted  output  1  high while in HALT.

Behaviour:
- Instruction fields:
  - [15:13] cond.
  - [12:10] action.
  - [9:8] reg select.
  - [7:0] imm.
- cond codes:
  - 000 always.
  - 001 c0==0.
  - 010 c0==1.
  - 011 c1==0.
  - 100 c1==1.
  - 101..111 never.
- action codes (actions execute only when cond is true):
  - 000 nop.
  - 001 write: reg[sel] <= imm.
  - 010 jump: pc <= imm[ADDR_W-1:0].
  - 011 halt.
  - 100..111 treated as nop.
- 16'h0000 is "always nop".
- c0 and c1 each pass through SYNC_STAGES flops. Conditions use only the final-stage values c0_s/c1_s.
  - An input change is visible to cond evaluation SYNC_STAGES edges later.
  - The synchronizers run regardless of en or state.
- FSM has two states, RUN and HALT.
  - Reset enters RUN.
  - RUN, en=1, one instruction per clock:
    - true jump: pc <= target.
    - true halt: state <= HALT, pc holds.
    - otherwise: pc <= pc+1, wrapping mod 2^ADDR_W (31 -> 0).
  - RUN, en=0: pc, registers and state hold; rom_addr still reflects pc.
  - HALT: pc and registers hold; halted=1.
    - resume=1 and en=1: state <= RUN and pc <= pc+1 on the same edge.
    - resume while en=0 is ignored.
- A write with a false cond changes nothing except pc (+1).
- A jump to its own address with a true cond is the busy-wait idiom; pc is stable until the cond goes false.
- Reset (asynchronous, any time, including mid-instruction): pc=0, reg0..3=0, sync flops=0, state=RUN, halted=0.
  - On deassertion, execution starts at address 0 on the first edge with en=1.
- rom_data is sampled only at the clock edge; it has no internal pipeline, so latency is 1 cycle from pc to effect.

Decomposition:
- Package picoctrl_pkg holds:
  - cond codes COND_ALWAYS..COND_NEVER;
  - action codes ACT_NOP/ACT_WRITE/ACT_JUMP/ACT_HALT;
  - field bit positions;
  - the FSM state typedef (RUN, HALT).
- The ROM uses the same package for instruction assembly.
- One sub-module: picoctrl_sync, a parameterized SYNC_STAGES-deep 1-bit synchronizer, instantiated for c0 and c1.

Test Plan:
- Reset/values:
  - Stimulus: reset_n low mid-run, with rom_data = {always, write, reg2, 8'hA5} executed before it.
  - Required: reg2_out=0xA5 before reset; on reset, all outputs 0 and rom_addr=0 immediately, without waiting for a clock edge.
- Busy-wait jump:
  - Stimulus: addr 1 = {c1==1, jump, 8'h01}, c1=1.
  - Required: rom_addr stays 1.
  - Stimulus: drop c1 to 0.
  - Required: rom_addr becomes 2 exactly SYNC_STAGES+1 edges after the change.
- Write sequence:
  - Stimulus: en=1, c0=0, ROM walking-one writes to reg0 at even addresses.
  - Required: reg0_out takes 0x01, 0x02, 0x04 on the edges executing addresses 0, 2, 4.
- Wrap-around:
  - Stimulus: pc=31, rom_data=0x0000.
  - Required: the next edge gives rom_addr=0.
- Halt/resume:
  - Stimulus: {always, halt} at addr 6.
  - Required: halted=1, rom_addr=6 held for 10 cycles.
  - Stimulus: resume with en=0.
  - Required: no change.
  - Stimulus: resume with en=1.
  - Required: halted=0, rom_addr=7 next edge.
- Enable:
  - Stimulus: en=0 for 5 cycles while c1 toggles.
  - Required: pc and registers frozen.
  - Stimulus: en=1.
  - Required: the first executed instruction uses the current synchronized c1.
